traffic_intersection_ctrl: RTL

Phase sequencer for a two-road intersection. It drives a red/green/yellow light set for the main road and for the side road, plus a pedestrian walk lamp. Phase lengths are counted in `tick` pulses from the shared prescaler. The main road rests on green until a side-road vehicle sensor or a latched pedestrian request demands service. This block sits above the single-light counter/lamp logic and replaces its free-running sequencing with a request-driven, conflict-free schedule.

---
 rtl/traffic_intersection_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - request-driven two-road intersection phase sequencer
//
// Purpose: sequences main/side road lamps and a pedestrian walk lamp through
// a conflict-free schedule. Main green is the resting phase; it is left only
// when a side-road vehicle or a latched pedestrian request asks for service.
// Phase lengths are counted in prescaler tick pulses.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   tick         in   one-cycle timebase enable for the phase timer
//   side_req     in   side-road vehicle sensor (level, not latched)
//   ped_req      in   pedestrian button (any high cycle is latched)
//   main_rgy     out  {red, green, yellow} for the main road
//   side_rgy     out  {red, green, yellow} for the side road
//   walk         out  pedestrian walk lamp
//   countdown    out  ticks remaining in the current phase, minus 1
//   ped_pending  out  pedestrian request latched and not yet served
//   phase        out  current state encoding

module traffic_intersection_ctrl #(
    parameter int T_MAIN_GREEN = 15,
    parameter int T_SIDE_GREEN = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALLRED     = 2,
    parameter int T_WALK       = 8,
    parameter int CW           = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          side_req,
    input  logic          ped_req,
    output logic [2:0]    main_rgy,
    output logic [2:0]    side_rgy,
    output logic          walk,
    output logic [CW-1:0] countdown,
    output logic          ped_pending,
    output logic [2:0]    phase
);

    typedef enum logic [2:0] {
        RST_RED     = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALLRED_A    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALLRED_B    = 3'd6,
        PED_WALK    = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    // Phase durations minus one, i.e. the countdown value loaded on entry.
    localparam logic [CW-1:0] LD_MAIN_GREEN = CW'(T_MAIN_GREEN - 1);
    localparam logic [CW-1:0] LD_SIDE_GREEN = CW'(T_SIDE_GREEN - 1);
    localparam logic [CW-1:0] LD_YELLOW     = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] LD_ALLRED     = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] LD_WALK       = CW'(T_WALK - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_load;
    logic          r_ped;
    logic          w_phase_end;
    logic          w_state_change;
    logic          w_enter_walk;

    // The reset phase reuses the all-red clearance length.
    function automatic logic [CW-1:0] load_value(input state_t s);
        logic [CW-1:0] v;
        case (s)
            MAIN_GREEN:  v = LD_MAIN_GREEN;
            MAIN_YELLOW: v = LD_YELLOW;
            SIDE_GREEN:  v = LD_SIDE_GREEN;
            SIDE_YELLOW: v = LD_YELLOW;
            PED_WALK:    v = LD_WALK;
            default:     v = LD_ALLRED;
        endcase
        return v;
    endfunction

    assign w_phase_end    = tick && (r_cnt == '0);
    assign w_state_change = (w_next != r_state);
    assign w_enter_walk   = (w_next == PED_WALK) && (r_state != PED_WALK);
    assign w_cnt_load     = load_value(w_next);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_RED;
        end else begin
            r_state <= w_next;
        end
    end

    // Countdown: reload on any state change; otherwise count down on tick and
    // park at zero, which is how main green waits for a request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= LD_ALLRED;
        end else if (w_state_change) begin
            r_cnt <= w_cnt_load;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // Pedestrian latch: a press in the same cycle as walk entry stays pending,
    // so the set term has priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped <= 1'b0;
        end else if (ped_req) begin
            r_ped <= 1'b1;
        end else if (w_enter_walk) begin
            r_ped <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_phase_end) begin
            case (r_state)
                RST_RED:     w_next = MAIN_GREEN;
                MAIN_GREEN:  w_next = (side_req || r_ped) ? MAIN_YELLOW : MAIN_GREEN;
                MAIN_YELLOW: w_next = ALLRED_A;
                ALLRED_A:    w_next = r_ped ? PED_WALK : SIDE_GREEN;
                PED_WALK:    w_next = side_req ? SIDE_GREEN : ALLRED_B;
                SIDE_GREEN:  w_next = SIDE_YELLOW;
                SIDE_YELLOW: w_next = ALLRED_B;
                ALLRED_B:    w_next = MAIN_GREEN;
                default:     w_next = RST_RED;
            endcase
        end
    end

    // Output decode (Moore)
    always_comb begin
        main_rgy = LAMP_RED;
        side_rgy = LAMP_RED;
        walk     = 1'b0;
        case (r_state)
            MAIN_GREEN:  main_rgy = LAMP_GREEN;
            MAIN_YELLOW: main_rgy = LAMP_YELLOW;
            SIDE_GREEN:  side_rgy = LAMP_GREEN;
            SIDE_YELLOW: side_rgy = LAMP_YELLOW;
            PED_WALK:    walk     = 1'b1;
            default: begin
                main_rgy = LAMP_RED;
                side_rgy = LAMP_RED;
                walk     = 1'b0;
            end
        endcase
    end

    assign phase       = r_state;
    assign countdown   = r_cnt;
    assign ped_pending = r_ped;

endmodule
